pwm_deadtime: RTL and testbench
===============================

# pwm_deadtime

Dead-time insertion stage directly downstream of the FOC core's SVM. It converts the three single-ended `pwmA/B/C` outputs into complementary high-side/low-side gate drives. Every gate transition gets a programmable break-before-make band, so the two switches of a phase are never on together. It also latches faults and forces all gates off on fault or disable.

## Interface
Parameters:
- `DT_WIDTH`, 8: width of the dead-time count.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rstb`  in  1  asynchronous, active-low reset.
- `pwmA_in`, `pwmB_in`, `pwmC_in`  in  1 each  phase commands from the SVM; 1 = high side on.
- `dead_time`  in  DT_WIDTH  dead band length; the band is `dead_time+1` cycles.
- `enable`  in  1  level; 1 = drive gates.
- `fault`  in  1  level, synchronous to `clk`; 1 = force gates off.
- `fault_clr`  in  1  single-cycle pulse; clears the latched fault.
- `gateAH`, `gateAL`, `gateBH`, `gateBL`, `gateCH`, `gateCL`  out  1 each  gate drives, registered.
- `fault_latched`  out  1  sticky fault flag.
- `running`  out  1  1 when no phase is in SAFE.

## Operation
- Input register `p_r[2:0]` samples `pwm*_in` every cycle. The FSM acts only on `p_r`.
- `dt_r` loads `dead_time` on every cycle in which the global state is SAFE. It is frozen otherwise, so changes while running are ignored.
- Per-phase FSM has five states, each decoded directly to the H/L gate outputs:
  - SAFE: H=0, L=0.
  - LOW_ON: H=0, L=1.
  - DEAD_R: H=0, L=0.
  - HIGH_ON: H=1, L=0.
  - DEAD_F: H=0, L=0.
- Every phase has its own down-counter `cnt` of width DT_WIDTH.
- Per-phase transitions, evaluated after the global rules below:
  - LOW_ON with p=1: go to DEAD_R, `cnt<=dt_r`.
  - HIGH_ON with p=0: go to DEAD_F, `cnt<=dt_r`.
  - DEAD_R with p=0: abort to LOW_ON (the same device re-closes, so no shoot-through).
  - DEAD_R with p=1: if `cnt==0` go to HIGH_ON, else `cnt<=cnt-1`.
  - DEAD_F mirrors DEAD_R: p=1 aborts to HIGH_ON; `cnt==0` goes to LOW_ON.
- Global rules, in priority order:
  1. `fault`=1: set `fault_latched`; all phases go to SAFE.
  2. `fault_latched`=1 or `enable`=0: all phases go to SAFE.
  3. Phase in SAFE, `enable`=1, `fault_latched`=0, `fault`=0: go to DEAD_R if p=1, else DEAD_F, with `cnt<=dt_r`. The first gate-on therefore always follows a full dead band.
- Fault clearing:
  - `fault_clr`=1 with `fault`=0 clears `fault_latched`.
  - If `fault` and `fault_clr` are both 1, `fault` wins and the flag stays set.
  - The clear does not re-enable gates in the same cycle. SAFE exit is evaluated from the next edge.
- `running` is registered and equals OR over the three phases of (state != SAFE).
- Invariant: H and L of one phase are never both 1 in any cycle. Across any H↔L handoff, both are 0 for at least `dt_r+1` cycles.

## Timing
- Reset values: every gate output, `fault_latched`, `running`, `p_r`, `dt_r` and all `cnt` are 0; all phases are in SAFE.
- Rising command, `pwmX_in` first sampled 1 at edge N (phase in LOW_ON):
  - L falls after edge N+1.
  - H rises after edge N+2+dt_r.
  - Both-off band is `dt_r+1` cycles, so `dead_time=0` still gives 1 cycle.
- A falling command is symmetric.
- Abort: input returns to its old value during the dead band. The original gate re-asserts one edge after the return is sampled, with no further delay.
- Fault sampled at edge N: all gates are 0 and `fault_latched`=1 after edge N. The response is one registered cycle, independent of state.
- `enable` falling at edge N: all gates are 0 after edge N+1.
- Reset asserted mid-operation: all gates drop to 0 immediately (asynchronous), and all state returns to reset values.
- The three phases are fully independent, and simultaneous transitions on multiple phases are allowed.

## Test plan
- Reset, then `enable`=1, `dead_time`=4, all pwm=0 → each L rises 5 cycles after SAFE exit; `running`=1; all H stay 0.
- `pwmA_in` 0→1 sampled at edge N, `dt_r`=4 → `gateAL` 0 after N+1; `gateAH` 1 after N+6; both 0 for exactly 5 cycles.
- `dead_time`=0 with `pwmB_in` toggling every 3 cycles → 1-cycle band on every handoff; H&L never both 1 (checked by assertion on all phases, all cycles).
- `dt_r`=10, `pwmC_in` 0→1 then back to 0 after 3 cycles → `gateCH` never asserts; `gateCL` re-asserts one edge after the return is sampled.
- `fault` pulse mid-DEAD_R and mid-HIGH_ON; `dead_time` changed to 20 while running → all gates 0 next edge, `fault_latched`=1; `fault_clr` with `fault`=1 keeps it set; `fault_clr` with `fault`=0 clears it; re-entry uses the new 20-cycle `dt_r` (21-cycle band).
- `rstb` asserted while phase A is in HIGH_ON → `gateAH` drops to 0 asynchronously; after release all outputs are at reset values until `enable`.

Source files
------------

// File: rtl/pwm_deadtime.sv
// rtl/pwm_deadtime.sv - three-phase complementary gate drive with dead-time insertion and fault latch
module pwm_deadtime #(
    parameter int DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                pwmA_in,
    input  logic                pwmB_in,
    input  logic                pwmC_in,
    input  logic [DT_WIDTH-1:0] dead_time,
    input  logic                enable,
    input  logic                fault,
    input  logic                fault_clr,
    output logic                gateAH,
    output logic                gateAL,
    output logic                gateBH,
    output logic                gateBL,
    output logic                gateCH,
    output logic                gateCL,
    output logic                fault_latched,
    output logic                running
);

    typedef enum logic [2:0] {
        ST_SAFE    = 3'd0,
        ST_LOW_ON  = 3'd1,
        ST_DEAD_R  = 3'd2,
        ST_HIGH_ON = 3'd3,
        ST_DEAD_F  = 3'd4
    } phase_state_t;

    localparam logic [DT_WIDTH-1:0] CNT_ONE  = {{(DT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DT_WIDTH-1:0] CNT_ZERO = '0;

    // Sampled phase commands, index 0 = A, 1 = B, 2 = C.
    logic [2:0]          p_q, p_d;
    // Dead-time snapshot, only refreshed while every phase is parked in SAFE.
    logic [DT_WIDTH-1:0] dt_q, dt_d;

    phase_state_t        state_q [3];
    phase_state_t        state_d [3];
    logic [DT_WIDTH-1:0] cnt_q   [3];
    logic [DT_WIDTH-1:0] cnt_d   [3];

    logic [2:0]          gate_h_q, gate_h_d;
    logic [2:0]          gate_l_q, gate_l_d;
    logic                fault_latched_q, fault_latched_d;
    logic                running_q, running_d;

    logic                all_safe;
    logic                force_safe;

    // Global conditions shared by all three phase machines.
    always_comb begin
        all_safe   = (state_q[0] == ST_SAFE) && (state_q[1] == ST_SAFE) &&
                     (state_q[2] == ST_SAFE);
        // The latched flag is the registered one, so a clear only lets the
        // phases leave SAFE from the following edge.
        force_safe = fault || fault_latched_q || !enable;
    end

    // Input sampling, dead-time snapshot and sticky fault flag.
    always_comb begin
        p_d  = {pwmC_in, pwmB_in, pwmA_in};
        dt_d = all_safe ? dead_time : dt_q;
        if (fault) begin
            fault_latched_d = 1'b1;
        end else if (fault_clr) begin
            fault_latched_d = 1'b0;
        end else begin
            fault_latched_d = fault_latched_q;
        end
    end

    // Per-phase break-before-make sequencing with abort back to the old device.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (force_safe) begin
                state_d[i] = ST_SAFE;
            end else begin
                case (state_q[i])
                    ST_SAFE: begin
                        // Leaving SAFE always passes through a full dead band.
                        state_d[i] = p_q[i] ? ST_DEAD_R : ST_DEAD_F;
                        cnt_d[i]   = dt_q;
                    end
                    ST_LOW_ON: begin
                        if (p_q[i]) begin
                            state_d[i] = ST_DEAD_R;
                            cnt_d[i]   = dt_q;
                        end
                    end
                    ST_DEAD_R: begin
                        if (!p_q[i]) begin
                            state_d[i] = ST_LOW_ON;
                        end else if (cnt_q[i] == CNT_ZERO) begin
                            state_d[i] = ST_HIGH_ON;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end
                    end
                    ST_HIGH_ON: begin
                        if (!p_q[i]) begin
                            state_d[i] = ST_DEAD_F;
                            cnt_d[i]   = dt_q;
                        end
                    end
                    ST_DEAD_F: begin
                        if (p_q[i]) begin
                            state_d[i] = ST_HIGH_ON;
                        end else if (cnt_q[i] == CNT_ZERO) begin
                            state_d[i] = ST_LOW_ON;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end
                    end
                    default: begin
                        state_d[i] = ST_SAFE;
                    end
                endcase
            end
        end
    end

    // Gate and status outputs are decoded from the next state so they are
    // registered alongside it and cannot glitch.
    always_comb begin
        running_d = 1'b0;
        for (int i = 0; i < 3; i++) begin
            gate_h_d[i] = (state_d[i] == ST_HIGH_ON);
            gate_l_d[i] = (state_d[i] == ST_LOW_ON);
            if (state_d[i] != ST_SAFE) begin
                running_d = 1'b1;
            end
        end
    end

    // State register; reset parks every gate off immediately.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            p_q             <= 3'b000;
            dt_q            <= '0;
            gate_h_q        <= 3'b000;
            gate_l_q        <= 3'b000;
            fault_latched_q <= 1'b0;
            running_q       <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= ST_SAFE;
                cnt_q[i]   <= '0;
            end
        end else begin
            p_q             <= p_d;
            dt_q            <= dt_d;
            gate_h_q        <= gate_h_d;
            gate_l_q        <= gate_l_d;
            fault_latched_q <= fault_latched_d;
            running_q       <= running_d;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign gateAH        = gate_h_q[0];
    assign gateAL        = gate_l_q[0];
    assign gateBH        = gate_h_q[1];
    assign gateBL        = gate_l_q[1];
    assign gateCH        = gate_h_q[2];
    assign gateCL        = gate_l_q[2];
    assign fault_latched = fault_latched_q;
    assign running       = running_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// tb/tb_pwm_deadtime.sv - vector table, directed corner sequences and random run against a reference model
module tb_pwm_deadtime;

    logic       clk = 1'b0;
    logic       rstb;
    logic       pa, pb, pc;
    logic [7:0] dead_time;
    logic       en, flt, clr;
    logic       gateAH, gateAL, gateBH, gateBL, gateCH, gateCL;
    logic       fault_latched, running;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    pwm_deadtime #(.DT_WIDTH(8)) dut (
        .clk(clk), .rstb(rstb),
        .pwmA_in(pa), .pwmB_in(pb), .pwmC_in(pc),
        .dead_time(dead_time), .enable(en), .fault(flt), .fault_clr(clr),
        .gateAH(gateAH), .gateAL(gateAL), .gateBH(gateBH), .gateBL(gateBL),
        .gateCH(gateCH), .gateCL(gateCL),
        .fault_latched(fault_latched), .running(running)
    );

    always #5 clk = ~clk;

    // Reference model: each phase is either parked, inside a dead band heading
    // for a target side, or conducting on one side.
    bit         m_parked [3];
    bit         m_inband [3];
    bit         m_goal   [3];
    bit         m_side   [3];
    int         m_remain [3];
    bit [2:0]   m_cmd;
    int         m_dt;
    bit         m_flag;

    function automatic logic [7:0] outs();
        return {gateAH, gateAL, gateBH, gateBL, gateCH, gateCL, fault_latched, running};
    endfunction

    function automatic logic [7:0] model_outs();
        logic [7:0] r;
        bit any_live;
        any_live = 1'b0;
        for (int i = 0; i < 3; i++) begin
            r[7-2*i] = !m_parked[i] && !m_inband[i] && m_side[i];
            r[6-2*i] = !m_parked[i] && !m_inband[i] && !m_side[i];
            if (!m_parked[i]) any_live = 1'b1;
        end
        r[1] = m_flag;
        r[0] = any_live;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_parked[i] = 1'b1;
            m_inband[i] = 1'b0;
            m_goal[i]   = 1'b0;
            m_side[i]   = 1'b0;
            m_remain[i] = 0;
        end
        m_cmd  = 3'b000;
        m_dt   = 0;
        m_flag = 1'b0;
    endtask

    task automatic model_step();
        bit everyone_parked;
        bit want;
        everyone_parked = m_parked[0] && m_parked[1] && m_parked[2];
        for (int i = 0; i < 3; i++) begin
            want = m_cmd[i];
            if (flt || m_flag || !en) begin
                m_parked[i] = 1'b1;
                m_inband[i] = 1'b0;
            end else if (m_parked[i]) begin
                m_parked[i] = 1'b0;
                m_inband[i] = 1'b1;
                m_goal[i]   = want;
                m_remain[i] = m_dt;
            end else if (m_inband[i]) begin
                if (want != m_goal[i]) begin
                    m_inband[i] = 1'b0;
                    m_side[i]   = want;
                end else if (m_remain[i] == 0) begin
                    m_inband[i] = 1'b0;
                    m_side[i]   = m_goal[i];
                end else begin
                    m_remain[i] = m_remain[i] - 1;
                end
            end else if (want != m_side[i]) begin
                m_inband[i] = 1'b1;
                m_goal[i]   = want;
                m_remain[i] = m_dt;
            end
        end
        if (flt) m_flag = 1'b1;
        else if (clr) m_flag = 1'b0;
        if (everyone_parked) m_dt = int'(dead_time);
        m_cmd = {pc, pb, pa};
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
        end
    endtask

    // One clock: sample after the edge, advance the model, compare everything.
    task automatic tick_m();
        logic [7:0] e;
        @(posedge clk);
        #1;
        cyc++;
        model_step();
        e = model_outs();
        checks++;
        if (outs() !== e) begin
            failures++;
            $display("FAIL model cyc=%0d got=%b exp=%b", cyc, outs(), e);
        end
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        {pc, pb, pa} = 3'b000;
        en = 1'b0; flt = 1'b0; clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", int'(outs()), 0);
        rstb = 1'b1;
    endtask

    // Shoot-through guard on every phase, every cycle.
    always @(negedge clk) begin
        if (rstb === 1'b1) begin
            checks++;
            if ((gateAH && gateAL) || (gateBH && gateBL) || (gateCH && gateCL)) begin
                failures++;
                $display("FAIL overlap t=%0t A=%b%b B=%b%b C=%b%b", $time,
                         gateAH, gateAL, gateBH, gateBL, gateCH, gateCL);
            end
        end
    end

    typedef struct {
        logic [2:0] pwm;
        logic       en;
        logic       flt;
        logic       clr;
        logic [7:0] dt;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [18];

    initial begin
        int first_k, fall_k, zeros;
        bit ch_seen;

        // Expected {AH,AL,BH,BL,CH,CL,fault_latched,running} after each edge; pwm is {C,B,A}.
        tbl[0]  = '{3'b000, 1'b0, 1'b0, 1'b0, 8'd2, 8'b00000000};
        tbl[1]  = '{3'b000, 1'b1, 1'b0, 1'b0, 8'd2, 8'b00000001};
        tbl[2]  = '{3'b000, 1'b1, 1'b0, 1'b0, 8'd2, 8'b00000001};
        tbl[3]  = '{3'b000, 1'b1, 1'b0, 1'b0, 8'd2, 8'b00000001};
        tbl[4]  = '{3'b000, 1'b1, 1'b0, 1'b0, 8'd2, 8'b01010101};
        tbl[5]  = '{3'b001, 1'b1, 1'b0, 1'b0, 8'd2, 8'b01010101};
        tbl[6]  = '{3'b001, 1'b1, 1'b0, 1'b0, 8'd2, 8'b00010101};
        tbl[7]  = '{3'b001, 1'b1, 1'b0, 1'b0, 8'd2, 8'b00010101};
        tbl[8]  = '{3'b001, 1'b1, 1'b0, 1'b0, 8'd2, 8'b00010101};
        tbl[9]  = '{3'b001, 1'b1, 1'b0, 1'b0, 8'd2, 8'b10010101};
        tbl[10] = '{3'b000, 1'b1, 1'b0, 1'b0, 8'd2, 8'b10010101};
        tbl[11] = '{3'b000, 1'b1, 1'b0, 1'b0, 8'd2, 8'b00010101};
        tbl[12] = '{3'b001, 1'b1, 1'b0, 1'b0, 8'd2, 8'b00010101};
        tbl[13] = '{3'b001, 1'b1, 1'b0, 1'b0, 8'd2, 8'b10010101};
        tbl[14] = '{3'b001, 1'b1, 1'b1, 1'b0, 8'd2, 8'b00000010};
        tbl[15] = '{3'b001, 1'b1, 1'b1, 1'b1, 8'd2, 8'b00000010};
        tbl[16] = '{3'b001, 1'b1, 1'b0, 1'b1, 8'd2, 8'b00000000};
        tbl[17] = '{3'b001, 1'b1, 1'b0, 1'b0, 8'd2, 8'b00000001};

        dead_time = 8'd2;
        do_reset();

        for (int r = 0; r < 18; r++) begin
            {pc, pb, pa} = tbl[r].pwm;
            en = tbl[r].en; flt = tbl[r].flt; clr = tbl[r].clr;
            dead_time = tbl[r].dt;
            tick_m();
            check($sformatf("vec%0d", r), int'(outs()), int'(tbl[r].exp));
        end

        // SAFE exit with dead_time=4: low sides after a 5-cycle band, then A rising.
        dead_time = 8'd4;
        do_reset();
        tick_m();
        en = 1'b1;
        tick_m();
        check("run_after_exit", int'(running), 1);
        first_k = -1;
        for (int k = 1; k <= 20; k++) begin
            tick_m();
            if (first_k < 0 && gateAL) first_k = k;
        end
        check("l_rise_k", first_k, 5);
        check("all_low", int'(outs()), 8'b01010101);
        pa = 1'b1;
        tick_m();
        fall_k = -1; first_k = -1; zeros = 0;
        for (int k = 1; k <= 20; k++) begin
            tick_m();
            if (fall_k < 0 && !gateAL) fall_k = k;
            if (first_k < 0 && gateAH) first_k = k;
            if (!gateAH && !gateAL) zeros++;
        end
        check("al_fall_k", fall_k, 1);
        check("ah_rise_k", first_k, 6);
        check("band_dt4", zeros, 5);

        // dead_time=0: B toggling every 3 cycles gives a single-cycle band each time.
        dead_time = 8'd0;
        do_reset();
        en = 1'b1;
        repeat (4) tick_m();
        zeros = 0;
        for (int t = 0; t < 8; t++) begin
            pb = ~pb;
            for (int k = 0; k < 3; k++) begin
                tick_m();
                if (!gateBH && !gateBL) zeros++;
            end
        end
        check("band_dt0", zeros, 8);

        // dt_r=10, C pulses high for 3 cycles: aborts back to low, high never fires.
        dead_time = 8'd10;
        do_reset();
        en = 1'b1;
        repeat (13) tick_m();
        check("c_low_ready", int'(gateCL), 1);
        ch_seen = 1'b0;
        pc = 1'b1;
        repeat (3) begin
            tick_m();
            if (gateCH) ch_seen = 1'b1;
        end
        pc = 1'b0;
        tick_m();
        check("cl_before_abort", int'(gateCL), 0);
        tick_m();
        check("cl_abort_back", int'(gateCL), 1);
        for (int k = 0; k < 15; k++) begin
            tick_m();
            if (gateCH) ch_seen = 1'b1;
        end
        check("ch_never", int'(ch_seen), 0);

        // Fault with A high and B in its dead band; dead_time moved to 20 while running.
        pa = 1'b1;
        repeat (15) tick_m();
        check("a_high", int'(gateAH), 1);
        pb = 1'b1;
        repeat (3) tick_m();
        dead_time = 8'd20;
        flt = 1'b1;
        tick_m();
        check("fault_off", int'(outs()), 8'b00000010);
        clr = 1'b1;
        tick_m();
        check("fault_wins", int'(fault_latched), 1);
        flt = 1'b0; clr = 1'b0;
        tick_m();
        check("fault_sticky", int'(fault_latched), 1);
        clr = 1'b1;
        tick_m();
        check("fault_cleared", int'(outs()), 8'b00000000);
        clr = 1'b0;
        tick_m();
        zeros = (!gateAH && !gateAL) ? 1 : 0;
        first_k = -1;
        for (int k = 1; k <= 30; k++) begin
            tick_m();
            if (first_k < 0 && gateAH) first_k = k;
            if (!gateAH && !gateAL) zeros++;
        end
        check("reentry_rise_k", first_k, 21);
        check("band_dt20", zeros, 21);

        // Asynchronous reset mid-cycle while A is high.
        #2;
        rstb = 1'b0;
        en = 1'b0;
        {pc, pb, pa} = 3'b000;
        #1;
        check("async_ah", int'(gateAH), 0);
        check("async_outs", int'(outs()), 0);
        model_reset();
        @(posedge clk);
        #1;
        rstb = 1'b1;
        pa = 1'b1;
        repeat (3) begin
            tick_m();
            check("idle_after_rst", int'(outs()), 0);
        end

        // Random traffic against the model.
        dead_time = 8'd3;
        do_reset();
        en = 1'b1;
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 7) == 0) pa = ~pa;
            if ($urandom_range(0, 7) == 0) pb = ~pb;
            if ($urandom_range(0, 7) == 0) pc = ~pc;
            if ($urandom_range(0, 63) == 0) en = ~en;
            if ($urandom_range(0, 9) == 0 && !en) en = 1'b1;
            flt = ($urandom_range(0, 99) == 0);
            clr = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) dead_time = 8'($urandom_range(0, 6));
            tick_m();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
